// File: rtl/zap_tlb_walker.sv
// zap_tlb_walker: hardware page-table walker for the ZAP MMU.
// On a TLB miss it fetches the first-level descriptor and, for coarse tables,
// the second-level descriptor over a Wishbone-style master port. It then
// writes one section / large-page / small-page TLB entry or reports a
// translation fault (FSR/FAR).
// TLB entry layout (MSB first): {tag, base, dac_sel, ap, cb}.
// Optional feature macro: ZAP_TLB_WALK_TIMEOUT_EN enables an ack watchdog
// that aborts a request after TIMEOUT_CYCLES cycles without an ack.
module zap_tlb_walker #(
  parameter int  TIMEOUT_CYCLES  = 255,
  localparam int SECTION_TLB_WDT = 32,
  localparam int LPAGE_TLB_WDT   = 46,
  localparam int SPAGE_TLB_WDT   = 54
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_walk,
  input  logic [31:0]                i_va,
  input  logic [31:0]                i_baddr,
  output logic                       o_wb_cyc,
  output logic                       o_wb_stb,
  output logic [31:0]                o_wb_adr,
  input  logic                       i_wb_ack,
  input  logic [31:0]                i_wb_dat,
  output logic                       o_setlb_wen,
  output logic [SECTION_TLB_WDT-1:0] o_setlb_wdata,
  output logic                       o_lptlb_wen,
  output logic [LPAGE_TLB_WDT-1:0]   o_lptlb_wdata,
  output logic                       o_sptlb_wen,
  output logic [SPAGE_TLB_WDT-1:0]   o_sptlb_wdata,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_fault,
  output logic [7:0]                 o_fsr,
  output logic [31:0]                o_far
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    L1_REQ = 2'd1,
    L2_REQ = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [31:0]                va_q, va_d;
  logic [3:0]                 l1_dom_q, l1_dom_d;   // domain of the coarse L1 descriptor
  logic [31:0]                adr_q, adr_d;
  logic                       cyc_q, cyc_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       fault_q, fault_d;
  logic [7:0]                 fsr_q, fsr_d;
  logic [31:0]                far_q, far_d;
  logic                       se_wen_q, se_wen_d;
  logic                       lp_wen_q, lp_wen_d;
  logic                       sp_wen_q, sp_wen_d;
  logic [SECTION_TLB_WDT-1:0] se_wdata_q, se_wdata_d;
  logic [LPAGE_TLB_WDT-1:0]   lp_wdata_q, lp_wdata_d;
  logic [SPAGE_TLB_WDT-1:0]   sp_wdata_q, sp_wdata_d;
  logic                       unused_s;

`ifdef ZAP_TLB_WALK_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_s;

  // The current cycle is the last one allowed without an ack.
  assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign unused_s  = ^i_baddr[13:0];
`else
  assign unused_s  = (^i_baddr[13:0]) ^ (TIMEOUT_CYCLES == 0);
`endif

  // Next-state, bus request and TLB/fault result computation.
  always_comb begin
    state_d    = state_q;
    va_d       = va_q;
    l1_dom_d   = l1_dom_q;
    adr_d      = adr_q;
    fsr_d      = fsr_q;
    far_d      = far_q;
    se_wdata_d = se_wdata_q;
    lp_wdata_d = lp_wdata_q;
    sp_wdata_d = sp_wdata_q;
    se_wen_d   = 1'b0;
    lp_wen_d   = 1'b0;
    sp_wen_d   = 1'b0;
    fault_d    = 1'b0;
`ifdef ZAP_TLB_WALK_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_walk) begin
          state_d = L1_REQ;
          va_d    = i_va;
          adr_d   = {i_baddr[31:14], i_va[31:20], 2'b00};
`ifdef ZAP_TLB_WALK_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      L1_REQ: begin
        if (i_wb_ack) begin
          case (i_wb_dat[1:0])
            2'b10: begin
              se_wdata_d = {va_q[31:20], i_wb_dat[31:20], i_wb_dat[8:5],
                            i_wb_dat[11:10], i_wb_dat[3:2]};
              se_wen_d   = 1'b1;
              state_d    = DONE;
            end
            2'b01: begin
              l1_dom_d = i_wb_dat[8:5];
              adr_d    = {i_wb_dat[31:10], va_q[19:12], 2'b00};
              state_d  = L2_REQ;
`ifdef ZAP_TLB_WALK_TIMEOUT_EN
              cnt_d    = '0;
`endif
            end
            default: begin
              fault_d = 1'b1;
              fsr_d   = {i_wb_dat[8:5], 4'b0101};
              far_d   = va_q;
              state_d = DONE;
            end
          endcase
        end else begin
`ifdef ZAP_TLB_WALK_TIMEOUT_EN
          if (timeout_s) begin
            fault_d = 1'b1;
            fsr_d   = {4'b0000, 4'b1100};
            far_d   = va_q;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
`else
          state_d = L1_REQ;
`endif
        end
      end
      L2_REQ: begin
        if (i_wb_ack) begin
          state_d = DONE;
          case (i_wb_dat[1:0])
            2'b01: begin
              lp_wdata_d = {va_q[31:16], i_wb_dat[31:16], l1_dom_q,
                            i_wb_dat[11:4], i_wb_dat[3:2]};
              lp_wen_d   = 1'b1;
            end
            2'b10: begin
              sp_wdata_d = {va_q[31:12], i_wb_dat[31:12], l1_dom_q,
                            i_wb_dat[11:4], i_wb_dat[3:2]};
              sp_wen_d   = 1'b1;
            end
            default: begin
              fault_d = 1'b1;
              fsr_d   = {l1_dom_q, 4'b0111};
              far_d   = va_q;
            end
          endcase
        end else begin
`ifdef ZAP_TLB_WALK_TIMEOUT_EN
          if (timeout_s) begin
            fault_d = 1'b1;
            fsr_d   = {l1_dom_q, 4'b1110};
            far_d   = va_q;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
`else
          state_d = L2_REQ;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cyc_d  = (state_d == L1_REQ) || (state_d == L2_REQ);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; reset abandons any walk in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      va_q       <= 32'd0;
      l1_dom_q   <= 4'd0;
      adr_q      <= 32'd0;
      cyc_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      fsr_q      <= 8'd0;
      far_q      <= 32'd0;
      se_wen_q   <= 1'b0;
      lp_wen_q   <= 1'b0;
      sp_wen_q   <= 1'b0;
      se_wdata_q <= '0;
      lp_wdata_q <= '0;
      sp_wdata_q <= '0;
`ifdef ZAP_TLB_WALK_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      va_q       <= va_d;
      l1_dom_q   <= l1_dom_d;
      adr_q      <= adr_d;
      cyc_q      <= cyc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      fsr_q      <= fsr_d;
      far_q      <= far_d;
      se_wen_q   <= se_wen_d;
      lp_wen_q   <= lp_wen_d;
      sp_wen_q   <= sp_wen_d;
      se_wdata_q <= se_wdata_d;
      lp_wdata_q <= lp_wdata_d;
      sp_wdata_q <= sp_wdata_d;
`ifdef ZAP_TLB_WALK_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = cyc_q;
  assign o_wb_adr      = adr_q;
  assign o_setlb_wen   = se_wen_q;
  assign o_setlb_wdata = se_wdata_q;
  assign o_lptlb_wen   = lp_wen_q;
  assign o_lptlb_wdata = lp_wdata_q;
  assign o_sptlb_wen   = sp_wen_q;
  assign o_sptlb_wdata = sp_wdata_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_fault       = fault_q;
  assign o_fsr         = fsr_q;
  assign o_far         = far_q;

endmodule

// File: tb/tb_zap_tlb_walker.sv
// Self-checking bench for zap_tlb_walker: directed vector table, hand-written
// reset / back-to-back / watchdog sequences and randomized walks checked
// against an arithmetic reference model of the page-table rules.
module tb_zap_tlb_walker;

  localparam int K_NONE  = -1;
  localparam int K_SEC   = 0;
  localparam int K_LP    = 1;
  localparam int K_SP    = 2;
  localparam int K_FAULT = 3;

  typedef struct {
    int          kind;
    logic [31:0] adr1;
    logic [31:0] adr2;
    logic [63:0] wdata;
    logic [7:0]  fsr;
    int          nreq;
    int          done_cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] baddr;
    logic [31:0] va;
    logic [31:0] l1;
    logic [31:0] l2;
    int          w1;
    int          w2;
    exp_t        e;
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] adr1;
    logic [31:0] adr2;
    logic [63:0] wdata;
    logic [7:0]  fsr;
    logic [31:0] far;
    int          nreq;
    int          done_cyc;
    int          proto;
    int          post_idle;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_walk = 1'b0;
  logic [31:0] i_va = 32'd0;
  logic [31:0] i_baddr = 32'd0;
  logic        ack = 1'b0;
  logic [31:0] dat = 32'd0;
  logic        o_wb_cyc, o_wb_stb, o_setlb_wen, o_lptlb_wen, o_sptlb_wen;
  logic        o_busy, o_done, o_fault;
  logic [31:0] o_wb_adr, o_far, o_setlb_wdata;
  logic [45:0] o_lptlb_wdata;
  logic [53:0] o_sptlb_wdata;
  logic [7:0]  o_fsr;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  m_fsr = 8'd0;
  logic [31:0] m_far = 32'd0;
  vec_t        vecs[6];

  zap_tlb_walker #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_walk(i_walk), .i_va(i_va), .i_baddr(i_baddr),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_adr(o_wb_adr),
    .i_wb_ack(ack), .i_wb_dat(dat),
    .o_setlb_wen(o_setlb_wen), .o_setlb_wdata(o_setlb_wdata),
    .o_lptlb_wen(o_lptlb_wen), .o_lptlb_wdata(o_lptlb_wdata),
    .o_sptlb_wen(o_sptlb_wen), .o_sptlb_wdata(o_sptlb_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault), .o_fsr(o_fsr), .o_far(o_far)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [31:0] b, va, l1, l2,
                              input int w1, w2, kind, input logic [31:0] a1, a2,
                              input logic [63:0] wd, input logic [7:0] fsr,
                              input int nreq, dc);
    vec_t v;
    v.name = n; v.baddr = b; v.va = va; v.l1 = l1; v.l2 = l2; v.w1 = w1; v.w2 = w2;
    v.e.kind = kind; v.e.adr1 = a1; v.e.adr2 = a2; v.e.wdata = wd; v.e.fsr = fsr;
    v.e.nreq = nreq; v.e.done_cyc = dc;
    return v;
  endfunction

  // Reference model: descriptor rules evaluated with plain arithmetic.
  function automatic exp_t model(input logic [31:0] baddr, va, l1, l2, input int w1, w2);
    exp_t        e;
    logic [63:0] dom, ap, cb;
    e.kind  = K_FAULT; e.adr2 = 32'd0; e.wdata = 64'd0; e.fsr = 8'd0;
    e.adr1  = (baddr & 32'hFFFF_C000) + (va / 32'd1048576) * 32'd4;
    dom     = 64'((l1 / 32'd32) % 32'd16);
    if (l1 % 32'd4 == 32'd2) begin
      e.kind  = K_SEC; e.nreq = 1; e.done_cyc = 2 + w1;
      e.wdata = 64'(va / 32'd1048576) * 64'd1048576 + 64'(l1 / 32'd1048576) * 64'd256
              + dom * 64'd16 + 64'((l1 / 32'd1024) % 32'd4) * 64'd4 + 64'((l1 / 32'd4) % 32'd4);
    end else if (l1 % 32'd4 == 32'd1) begin
      e.nreq = 2; e.done_cyc = 3 + w1 + w2;
      e.adr2 = (l1 & 32'hFFFF_FC00) + ((va / 32'd4096) % 32'd256) * 32'd4;
      ap = 64'((l2 / 32'd16) % 32'd256);
      cb = 64'((l2 / 32'd4) % 32'd4);
      if (l2 % 32'd4 == 32'd1) begin
        e.kind  = K_LP;
        e.wdata = 64'(va / 32'd65536) * (64'd1 << 30) + 64'(l2 / 32'd65536) * 64'd16384
                + dom * 64'd1024 + ap * 64'd4 + cb;
      end else if (l2 % 32'd4 == 32'd2) begin
        e.kind  = K_SP;
        e.wdata = 64'(va / 32'd4096) * (64'd1 << 34) + 64'(l2 / 32'd4096) * 64'd16384
                + dom * 64'd1024 + ap * 64'd4 + cb;
      end else begin
        e.fsr = 8'(dom * 64'd16 + 64'd7);
      end
    end else begin
      e.nreq = 1; e.done_cyc = 2 + w1;
      e.fsr  = 8'(dom * 64'd16 + 64'd5);
    end
    return e;
  endfunction

  // Runs one walk as the bus slave; called and returning at a falling edge.
  task automatic run_walk(input logic [31:0] baddr, va, l1, l2, input int w1, w2,
                          input bit noise, output obs_t o);
    int          ridx, wc, nw;
    int          ws[2];
    logic [31:0] ds[2];
    logic [31:0] adrs[2];
    ws[0] = w1; ws[1] = w2; ds[0] = l1; ds[1] = l2; adrs[0] = 32'd0; adrs[1] = 32'd0;
    o.kind = K_NONE; o.wdata = 64'd0; o.fsr = 8'd0; o.far = 32'd0; o.proto = 0;
    o.done_cyc = 0; o.post_idle = 0;
    ridx = 0; wc = 0;
    i_walk = 1'b1; i_va = va; i_baddr = baddr; ack = 1'b0;
    for (int c = 1; c <= 80 && o.done_cyc == 0; c++) begin
      @(negedge clk);
      i_walk = 1'b0; i_va = $urandom; i_baddr = $urandom;
      nw = int'(o_setlb_wen) + int'(o_lptlb_wen) + int'(o_sptlb_wen);
      if (o_wb_cyc != o_wb_stb || nw > 1 || (nw == 1 && !o_done) || (o_fault && !o_done)
          || (o_done && o_wb_cyc) || (!o_done && !o_busy)) o.proto++;
      if (o_done) begin
        o.done_cyc = c; o.fsr = o_fsr; o.far = o_far;
        if (o_fault) o.kind = K_FAULT;
        else if (o_setlb_wen) begin o.kind = K_SEC; o.wdata = 64'(o_setlb_wdata); end
        else if (o_lptlb_wen) begin o.kind = K_LP;  o.wdata = 64'(o_lptlb_wdata); end
        else if (o_sptlb_wen) begin o.kind = K_SP;  o.wdata = 64'(o_sptlb_wdata); end
        ack = noise ? 1'($urandom_range(0, 1)) : 1'b0; dat = $urandom;
      end else if (o_wb_cyc && ridx < 2) begin
        if (wc == 0) adrs[ridx] = o_wb_adr;
        else if (o_wb_adr != adrs[ridx]) o.proto++;
        if (wc == ws[ridx]) begin ack = 1'b1; dat = ds[ridx]; ridx++; wc = 0; end
        else begin ack = 1'b0; dat = $urandom; wc++; end
      end else begin
        if (o_wb_cyc) o.proto++;
        ack = noise ? 1'($urandom_range(0, 1)) : 1'b0; dat = $urandom;
      end
    end
    if (o.done_cyc == 0) o.done_cyc = 81;
    o.adr1 = adrs[0]; o.adr2 = adrs[1]; o.nreq = ridx;
    @(negedge clk);
    ack = 1'b0;
    o.post_idle = (!o_busy && !o_done && !o_wb_cyc) ? 1 : 0;
  endtask

  task automatic compare(input string t, input obs_t o, input exp_t e, input logic [31:0] va);
    check({t, ".done_cycle"}, 64'(o.done_cyc), 64'(e.done_cyc));
    check({t, ".kind"}, 64'(o.kind), 64'(e.kind));
    check({t, ".adr1"}, 64'(o.adr1), 64'(e.adr1));
    check({t, ".nreq"}, 64'(o.nreq), 64'(e.nreq));
    if (e.nreq == 2) check({t, ".adr2"}, 64'(o.adr2), 64'(e.adr2));
    check({t, ".protocol"}, 64'(o.proto), 64'd0);
    check({t, ".idle_after"}, 64'(o.post_idle), 64'd1);
    if (e.kind == K_FAULT) begin
      m_fsr = e.fsr; m_far = va;
    end else begin
      check({t, ".wdata"}, o.wdata, e.wdata);
    end
    check({t, ".fsr"}, 64'(o.fsr), 64'(m_fsr));
    check({t, ".far"}, 64'(o.far), 64'(m_far));
  endtask

  initial begin
    obs_t        o;
    exp_t        e;
    logic [31:0] rb, rv, r1, r2;
    int          w1, w2, cnt, ncyc, dcyc;
    logic        seen, tf;
    logic [7:0]  tfsr;
    logic [31:0] tfar;

    vecs[0] = mk("section", 32'h0000_4000, 32'h1234_5678, 32'h8760_0C2E, 32'h0, 0, 0,
                 K_SEC, 32'h0000_448C, 32'h0, 64'h1238_761F, 8'h00, 1, 2);
    vecs[1] = mk("small", 32'h0000_4000, 32'h0003_4000, 32'h0010_0021, 32'hABCD_EFFE, 0, 0,
                 K_SP, 32'h0000_4000, 32'h0010_00D0, 64'hD2_AF37_87FF, 8'h00, 2, 3);
    vecs[2] = mk("large", 32'h0000_4000, 32'h0003_4000, 32'h0010_0021, 32'h5555_0FF5, 0, 0,
                 K_LP, 32'h0000_4000, 32'h0010_00D0, 64'hD555_47FD, 8'h00, 2, 3);
    vecs[3] = mk("l1_fault", 32'h0000_4000, 32'hCAFE_BABE, 32'h0000_0040, 32'h0, 0, 0,
                 K_FAULT, 32'h0000_72BC, 32'h0, 64'h0, 8'h25, 1, 2);
    vecs[4] = mk("l2_fault", 32'h0000_4000, 32'h00FF_F000, 32'h0020_0061, 32'h0, 0, 0,
                 K_FAULT, 32'h0000_403C, 32'h0020_03FC, 64'h0, 8'h37, 2, 3);
    vecs[5] = mk("section_wait", 32'hFFFF_C123, 32'hFFF0_0000, 32'hFFFF_FFFE, 32'h0, 3, 0,
                 K_SEC, 32'hFFFF_FFFC, 32'h0, 64'hFFFF_FFFF, 8'h00, 1, 5);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(|{o_wb_cyc, o_wb_stb, o_wb_adr, o_setlb_wen, o_setlb_wdata,
          o_lptlb_wen, o_lptlb_wdata, o_sptlb_wen, o_sptlb_wdata, o_busy, o_done, o_fault,
          o_fsr, o_far}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_walk(vecs[i].baddr, vecs[i].va, vecs[i].l1, vecs[i].l2, vecs[i].w1, vecs[i].w2,
               1'b0, o);
      compare(vecs[i].name, o, vecs[i].e, vecs[i].va);
    end

    // Reset in the middle of a second-level fetch
    i_baddr = 32'h0000_4000; i_va = 32'h00FF_F000; i_walk = 1'b1; ack = 1'b0;
    @(negedge clk); i_walk = 1'b0; ack = 1'b1; dat = 32'h0020_0061;
    @(negedge clk); ack = 1'b0;
    check("rst_pre_l2_cyc", 64'(o_wb_cyc), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 64'(|{o_wb_cyc, o_wb_stb, o_wb_adr, o_setlb_wen, o_setlb_wdata,
          o_lptlb_wen, o_lptlb_wdata, o_sptlb_wen, o_sptlb_wdata, o_busy, o_done, o_fault,
          o_fsr, o_far}), 64'd0);
    @(negedge clk); rst_n = 1'b1; m_fsr = 8'd0; m_far = 32'd0;
    seen = 1'b0;
    repeat (6) begin
      ack = 1'b1; dat = $urandom;
      @(negedge clk);
      seen = seen | o_done | o_fault | o_setlb_wen | o_lptlb_wen | o_sptlb_wen | o_wb_cyc;
    end
    ack = 1'b0;
    check("rst_no_write_after", 64'(seen), 64'd0);

    // Request held high: each re-miss starts only after the IDLE cycle
    cnt = 0; i_walk = 1'b1; i_va = 32'h0040_0000; i_baddr = 32'h0000_8000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      cnt += int'(o_done);
      if (o_wb_cyc) begin ack = 1'b1; dat = 32'h0000_0002; end
      else ack = 1'b0;
    end
    i_walk = 1'b0; ack = 1'b0;
    check("back_to_back_done_count", 64'(cnt), 64'd3);
    repeat (2) @(negedge clk);

`ifdef ZAP_TLB_WALK_TIMEOUT_EN
    // Watchdog: never acknowledge the first-level fetch
    i_walk = 1'b1; i_va = 32'h89AB_CDEF; i_baddr = 32'h0000_4000; ack = 1'b0;
    ncyc = 0; dcyc = 0; tf = 1'b0; tfsr = 8'd0; tfar = 32'd0;
    for (int c = 1; c <= 20 && dcyc == 0; c++) begin
      @(negedge clk);
      i_walk = 1'b0;
      ncyc += int'(o_wb_cyc);
      if (o_done) begin dcyc = c; tf = o_fault; tfsr = o_fsr; tfar = o_far; end
    end
    check("timeout_done_cycle", 64'(dcyc), 64'd5);
    check("timeout_req_cycles", 64'(ncyc), 64'd4);
    check("timeout_fault", 64'(tf), 64'd1);
    check("timeout_fsr", 64'(tfsr), 64'h0C);
    check("timeout_far", 64'(tfar), 64'h89AB_CDEF);
    m_fsr = 8'h0C; m_far = 32'h89AB_CDEF;
    repeat (2) @(negedge clk);
`endif

    // Randomized walks against the reference model
    for (int i = 0; i < 40; i++) begin
      rb = $urandom; rv = $urandom; r1 = $urandom; r2 = $urandom;
      r1[1:0] = 2'($urandom_range(0, 3));
      r2[1:0] = 2'($urandom_range(0, 3));
      w1 = $urandom_range(0, 3); w2 = $urandom_range(0, 3);
      e = model(rb, rv, r1, r2, w1, w2);
      run_walk(rb, rv, r1, r2, w1, w2, 1'b1, o);
      compare($sformatf("rand%0d", i), o, e, rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
